multiply: RTL and testbench

- Pipelined signed complex-number multiplier: c = a * b, i.e. Re(c) = Re(a)Re(b) − Im(a)Im(b) and Im(c) = Re(a)Im(b) + Im(a)Re(b).
- Operands and result use the codebase's packed complex format: real part in the upper half, imaginary part in the lower half, each a two's-complement signed field.
- Sits in the DSP datapath and accepts one operand pair per clock; there is no backpressure.

---
 rtl/multiply.sv | 75 +++++++
 tb/tb_multiply.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multiply.sv
// Two-stage pipelined signed complex multiplier on packed {re, im} operands.
// Stage 1 registers the four partial products; stage 2 forms the sums, wraps to W bits and flags overflow.
module multiply #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic [2*W-1:0] c,
    output logic           out_valid,
    output logic           ovf
);

    localparam int PW = 2 * W;

    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic signed [PW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
    logic signed [PW-1:0] rr, ii, ri, ir;
    logic                 s1_valid;
    logic signed [PW:0]   re_full, im_full;
    logic                 re_ovf, im_ovf;

    assign a_re = a[2*W-1:W];
    assign a_im = a[W-1:0];
    assign b_re = b[2*W-1:W];
    assign b_im = b[W-1:0];

    // Products are formed at 2W bits so that -2^(W-1) * -2^(W-1) is exact.
    assign a_re_x = {{W{a_re[W-1]}}, a_re};
    assign a_im_x = {{W{a_im[W-1]}}, a_im};
    assign b_re_x = {{W{b_re[W-1]}}, b_re};
    assign b_im_x = {{W{b_im[W-1]}}, b_im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= '0;
            ii       <= '0;
            ri       <= '0;
            ir       <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                rr <= a_re_x * b_re_x;
                ii <= a_im_x * b_im_x;
                ri <= a_re_x * b_im_x;
                ir <= a_im_x * b_re_x;
            end
        end
    end

    assign re_full = {rr[PW-1], rr} - {ii[PW-1], ii};
    assign im_full = {ri[PW-1], ri} + {ir[PW-1], ir};

    // A sum fits in W bits only when every bit from W-1 upward equals the sign.
    assign re_ovf = !((&re_full[PW:W-1]) || !(|re_full[PW:W-1]));
    assign im_ovf = !((&im_full[PW:W-1]) || !(|im_full[PW:W-1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                c   <= {re_full[W-1:0], im_full[W-1:0]};
                ovf <= re_ovf | im_ovf;
            end
        end
    end

endmodule

// File: tb/tb_multiply.sv
// Directed and randomized checks of the complex multiplier against hand-computed
// values and an independent full-precision model.
module tb_multiply;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic [2*W-1:0] c;
    logic           out_valid;
    logic           ovf;

    int checks;
    int failures;

    // Expected pipeline: index 0 is the operand just sampled, index 1 is what c shows.
    logic        p_v [2];
    logic [31:0] p_c [2];
    logic        p_o [2];

    multiply #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .out_valid(out_valid),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int re, input int im);
        logic [31:0] r;
        r = {re[15:0], im[15:0]};
        return r;
    endfunction

    // Full-precision reference: returns {ovf, c}.
    function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv);
        longint ar, ai, br, bi, re, im;
        logic   ov;
        ar = longint'($signed(av[31:16]));
        ai = longint'($signed(av[15:0]));
        br = longint'($signed(bv[31:16]));
        bi = longint'($signed(bv[15:0]));
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        ov = (re > 32767) || (re < -32768) || (im > 32767) || (im < -32768);
        return {ov, re[15:0], im[15:0]};
    endfunction

    task automatic clearPipe();
        for (int i = 0; i < 2; i++) begin
            p_v[i] = 1'b0;
            p_c[i] = '0;
            p_o[i] = 1'b0;
        end
    endtask

    // Drives one cycle of input, advances one edge, then checks the output stage.
    task automatic applyStimulus(input string tag, input logic v, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [31:0] ec, input logic eo);
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        p_v[1] = p_v[0];
        p_c[1] = p_c[0];
        p_o[1] = p_o[0];
        p_v[0] = v;
        p_c[0] = ec;
        p_o[0] = eo;
        checkOutput({tag, ":out_valid"}, 64'(out_valid), 64'(p_v[1]));
        if (p_v[1]) begin
            checkOutput({tag, ":c"}, 64'(c), 64'(p_c[1]));
            checkOutput({tag, ":ovf"}, 64'(ovf), 64'(p_o[1]));
        end
    endtask

    task automatic modelStimulus(input string tag, input logic v, input logic [31:0] av,
                                 input logic [31:0] bv);
        logic [32:0] m;
        m = model(av, bv);
        applyStimulus(tag, v, av, bv, m[31:0], m[32]);
    endtask

    task automatic assertReset(input string tag);
        rst_n = 1'b0;
        #1;
        clearPipe();
        checkOutput({tag, ":rst_c"}, 64'(c), 64'd0);
        checkOutput({tag, ":rst_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ":rst_ovf"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clearPipe();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = pack(1234, -77);
        b        = pack(-500, 31);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset:c", 64'(c), 64'd0);
        checkOutput("reset:out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset:ovf", 64'(ovf), 64'd0);

        in_valid = 1'b0;
        rst_n    = 1'b1;
        applyStimulus("idle", 1'b0, '0, '0, '0, 1'b0);

        applyStimulus("d0", 1'b1, pack(-10, 5), pack(3, -8), pack(10, 95), 1'b0);
        applyStimulus("d1", 1'b1, pack(6, 3), pack(2, -6), pack(30, -30), 1'b0);
        applyStimulus("d2", 1'b1, pack(2, 8), pack(0, 2), pack(-16, 4), 1'b0);
        applyStimulus("d3", 1'b1, pack(4, 1), pack(-2, -7), pack(-1, -30), 1'b0);
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);

        applyStimulus("wrap", 1'b1, pack(-32768, 0), pack(-32768, 0), pack(0, 0), 1'b1);
        applyStimulus("fit", 1'b1, pack(181, 0), pack(181, 0), pack(32761, 0), 1'b0);
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);

        begin
            logic pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++)
                modelStimulus("gap", pattern[i], $urandom, $urandom);
        end
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);

        applyStimulus("mid0", 1'b1, pack(100, 200), pack(3, 4), pack(-500, 1000), 1'b0);
        applyStimulus("mid1", 1'b1, pack(7, -7), pack(7, 7), pack(98, 0), 1'b0);
        assertReset("mid");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus("post_rst", 1'b0, '0, '0, '0, 1'b0);

        for (int i = 0; i < 10000; i++)
            modelStimulus("rand", 1'($urandom_range(0, 1)), $urandom, $urandom);
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);
        applyStimulus("flush", 1'b0, '0, '0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
